ddio_acq_sequencer: RTL and testbench

Controller that sequences one DDIO sample-capture burst: it enables the DDIO input path, waits for it to settle, and writes a programmed number of samples into the downstream FIFO. It stalls on FIFO back-pressure, flushes, and reports completion or timeout. It contains the FSM next-state logic and its own state register. It sits between the control interface (start/abort/length) and the DDIO capture datapath / sample FIFO, all on the PLL clock.

---
 rtl/acq_seq_pkg.sv | 16 +
 rtl/acq_state_reg.sv | 19 +
 rtl/ddio_acq_sequencer.sv | 146 ++++++++++++++
 tb/tb_ddio_acq_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_seq_pkg.sv
// Shared state encoding for the DDIO acquisition sequencer.
package acq_seq_pkg;

  localparam int ACQ_STATE_W = 3;

  typedef enum logic [ACQ_STATE_W-1:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    STALL   = 3'd3,
    FLUSH   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } acq_state_e;

endpackage

// File: rtl/acq_state_reg.sv
// State register for the acquisition sequencer: loads state_next every clock,
// synchronous active-low reset to IDLE.
module acq_state_reg
  import acq_seq_pkg::*;
#(
  parameter int STATE_W = ACQ_STATE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_next,
  output logic [STATE_W-1:0] state_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= STATE_W'(IDLE);
    else        state_q <= state_next;
  end

endmodule

// File: rtl/ddio_acq_sequencer.sv
// Sequences one DDIO capture burst: settle the input path, write cfg_len samples
// to the FIFO with back-pressure handling, flush, then report done or timeout.
module ddio_acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int STATE_W     = 3,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int FLUSH_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic               sample_valid_in,
  input  logic               ready_out,
  output logic               capture_en,
  output logic               wr_en,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic               overrun,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [STATE_W-1:0] state_reg
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int FLS_W = $clog2(FLUSH_CYC + 1);
  localparam int STL_W = $clog2(TIMEOUT_CYC);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [FLS_W-1:0] FLUSH_LAST  = FLS_W'(FLUSH_CYC - 1);
  localparam logic [STL_W-1:0] STALL_LAST  = STL_W'(TIMEOUT_CYC - 1);

  logic [STATE_W-1:0] state_raw;
  acq_state_e         state_q;
  acq_state_e         state_d;

  logic [CNT_W-1:0] len_q;
  logic [SET_W-1:0] settle_cnt;
  logic [FLS_W-1:0] flush_cnt;
  logic [STL_W-1:0] stall_cnt;

  logic start_ok;
  logic last_sample;

  acq_state_reg #(.STATE_W(STATE_W)) u_state_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .state_next (STATE_W'(state_d)),
    .state_q    (state_raw)
  );

  assign state_q     = acq_state_e'(state_raw);
  assign state_reg   = state_raw;
  assign start_ok    = start && (cfg_len != '0);
  assign last_sample = (sample_cnt == (len_q - CNT_W'(1)));

  assign capture_en = (state_q == SETTLE) || (state_q == CAPTURE) || (state_q == STALL);
  assign busy       = (state_q == SETTLE) || (state_q == CAPTURE) || (state_q == STALL) ||
                      (state_q == FLUSH)  || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign wr_en      = (state_q == CAPTURE) && sample_valid_in && ready_out;

  // Next state; reset lives in the state register, abort overrides everything else.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ERROR: if (start_ok) state_d = SETTLE;
        SETTLE:      if (settle_cnt == SETTLE_LAST) state_d = CAPTURE;
        CAPTURE: begin
          if (wr_en && last_sample) state_d = FLUSH;
          else if (!ready_out)      state_d = STALL;
        end
        STALL: begin
          if (ready_out)                    state_d = CAPTURE;
          else if (stall_cnt == STALL_LAST) state_d = ERROR;
        end
        FLUSH:   if (flush_cnt == FLUSH_LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      sample_cnt  <= '0;
      settle_cnt  <= '0;
      flush_cnt   <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (abort) begin
      sample_cnt <= '0;
      settle_cnt <= '0;
      flush_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start_ok) begin
            len_q       <= cfg_len;
            sample_cnt  <= '0;
            settle_cnt  <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
          else                           settle_cnt <= settle_cnt + SET_W'(1);
        end
        CAPTURE: begin
          if (wr_en) sample_cnt <= sample_cnt + CNT_W'(1);
          stall_cnt <= '0;
          flush_cnt <= '0;
        end
        STALL: begin
          // A sample arriving while the FIFO is full is lost; remember that it happened.
          if (sample_valid_in) overrun <= 1'b1;
          if (ready_out) begin
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_LAST) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + STL_W'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) flush_cnt <= '0;
          else                         flush_cnt <= flush_cnt + FLS_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddio_acq_sequencer.sv
// Bench for ddio_acq_sequencer: directed scenarios plus random traffic, every
// cycle compared against a countdown-style behavioural model.
module tb_ddio_acq_sequencer;

  localparam int STATE_W     = 3;
  localparam int CNT_W       = 16;
  localparam int SETTLE_CYC  = 8;
  localparam int FLUSH_CYC   = 2;
  localparam int TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, sample_valid_in, ready_out;
  logic [CNT_W-1:0] cfg_len;
  logic             capture_en, wr_en, busy, done, timeout_err, overrun;
  logic [CNT_W-1:0] sample_cnt;
  logic [STATE_W-1:0] state_reg;

  ddio_acq_sequencer #(
    .STATE_W(STATE_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC),
    .FLUSH_CYC(FLUSH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
    .sample_valid_in(sample_valid_in), .ready_out(ready_out),
    .capture_en(capture_en), .wr_en(wr_en), .busy(busy), .done(done),
    .timeout_err(timeout_err), .overrun(overrun), .sample_cnt(sample_cnt),
    .state_reg(state_reg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: mode number, remaining settle/flush cycles, stall length so far.
  int m_mode, m_settle_left, m_flush_left, m_stall, m_written, m_len;
  bit m_terr, m_ovr;

  // Last observed DUT outputs, for the directed scenario bookkeeping.
  int   cyc = 0;
  int   o_state, o_cnt;
  logic o_wr, o_done, o_cap, o_busy, o_terr, o_ovr;

  task automatic model_reset();
    m_mode = 0; m_settle_left = 0; m_flush_left = 0; m_stall = 0;
    m_written = 0; m_len = 0; m_terr = 0; m_ovr = 0;
  endtask

  task automatic step(input bit rs, input bit st, input bit ab, input int len,
                      input bit v, input bit r);
    bit exp_wr;
    rst_n = rs; start = st; abort = ab; cfg_len = len[CNT_W-1:0];
    sample_valid_in = v; ready_out = r;
    @(negedge clk);
    o_state = 32'(state_reg); o_cnt = 32'(sample_cnt);
    o_wr = wr_en; o_done = done; o_cap = capture_en; o_busy = busy;
    o_terr = timeout_err; o_ovr = overrun;
    exp_wr = (m_mode == 2) && v && r;
    chk("state_reg",   32'(state_reg),   32'(m_mode));
    chk("wr_en",       32'(wr_en),       32'(exp_wr));
    chk("capture_en",  32'(capture_en),  32'(m_mode >= 1 && m_mode <= 3));
    chk("busy",        32'(busy),        32'(m_mode >= 1 && m_mode <= 5));
    chk("done",        32'(done),        32'(m_mode == 5));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("overrun",     32'(overrun),     32'(m_ovr));
    chk("sample_cnt",  32'(sample_cnt),  32'(m_written));
    if (!rs) begin
      model_reset();
    end else if (ab) begin
      m_mode = 0; m_settle_left = 0; m_flush_left = 0; m_stall = 0; m_written = 0;
    end else begin
      case (m_mode)
        0, 6: if (st && len != 0) begin
          m_mode = 1; m_len = len; m_written = 0; m_terr = 0; m_ovr = 0;
          m_settle_left = SETTLE_CYC;
        end
        1: begin
          m_settle_left--;
          if (m_settle_left == 0) m_mode = 2;
        end
        2: begin
          if (v && r) begin
            m_written++;
            if (m_written == m_len) begin m_mode = 4; m_flush_left = FLUSH_CYC; end
          end else if (!r) begin
            m_mode = 3; m_stall = 0;
          end
        end
        3: begin
          if (v) m_ovr = 1;
          m_stall++;
          if (r) m_mode = 2;
          else if (m_stall == TIMEOUT_CYC) begin m_mode = 6; m_terr = 1; end
        end
        4: begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = 5;
        end
        default: m_mode = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0, first_cap, first_wr, last_wr, nwr, done_cyc, busy_low, low_left;
    int stall_cyc, wr_in_stall;
    bit saw_stall, saw_done, saw_busy;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0;
    sample_valid_in = 1'b0; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_state", 32'(state_reg), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_cap",   32'(capture_en), 0);
    chk("rst_cnt",   32'(sample_cnt), 0);
    chk("rst_flags", 32'({timeout_err, overrun, done}), 0);

    // Basic burst, len 4, valid/ready high
    t0 = cyc; first_cap = -1; first_wr = -1; last_wr = -1; nwr = 0;
    done_cyc = -1; busy_low = -1; saw_busy = 0;
    step(1, 1, 0, 4, 1, 1);
    repeat (19) begin
      step(1, 0, 0, 4, 1, 1);
      if (o_cap && first_cap < 0) first_cap = cyc - 1 - t0;
      if (o_wr) begin nwr++; if (first_wr < 0) first_wr = cyc - 1 - t0; last_wr = cyc - 1 - t0; end
      if (o_done && done_cyc < 0) done_cyc = cyc - 1 - t0;
      if (o_busy) saw_busy = 1;
      else if (saw_busy && busy_low < 0) busy_low = cyc - 1 - t0;
    end
    chk("basic_cap_rise", 32'(first_cap), 1);
    chk("basic_wr_first", 32'(first_wr), 9);
    chk("basic_wr_last",  32'(last_wr), 12);
    chk("basic_nwr",      32'(nwr), 4);
    chk("basic_done_cyc", 32'(done_cyc), 15);
    chk("basic_busy_low", 32'(busy_low), 16);
    chk("basic_cnt",      32'(sample_cnt), 4);

    // Back-pressure, len 6, ready low 3 cycles after the 2nd write
    nwr = 0; low_left = 0; saw_stall = 0; saw_done = 0; wr_in_stall = 0;
    step(1, 1, 0, 6, 1, 1);
    repeat (40) begin
      step(1, 0, 0, 6, 1, low_left == 0);
      if (low_left > 0) low_left--;
      if (o_state == 3) begin saw_stall = 1; if (o_wr) wr_in_stall++; end
      if (o_wr) begin nwr++; if (nwr == 2) low_left = 3; end
      if (o_done) saw_done = 1;
    end
    chk("bp_stall_seen",  32'(saw_stall), 1);
    chk("bp_wr_in_stall", 32'(wr_in_stall), 0);
    chk("bp_nwr",         32'(nwr), 6);
    chk("bp_done",        32'(saw_done), 1);
    chk("bp_overrun",     32'(overrun), 1);

    // Timeout: ready held low once capturing
    stall_cyc = 0;
    step(1, 1, 0, 5, 1, 1);
    repeat (40) begin
      step(1, 0, 0, 5, 1, 0);
      if (o_state == 3) stall_cyc++;
    end
    chk("to_stall_cycles", 32'(stall_cyc), TIMEOUT_CYC);
    chk("to_state",        32'(state_reg), 6);
    chk("to_err_held",     32'(timeout_err), 1);
    nwr = 0; saw_done = 0;
    step(1, 1, 0, 3, 1, 1);
    step(1, 0, 0, 3, 1, 1);
    chk("to_err_cleared", 32'(o_terr), 0);
    repeat (20) begin
      step(1, 0, 0, 3, 1, 1);
      if (o_wr) nwr++;
      if (o_done) saw_done = 1;
    end
    chk("to_rerun_nwr",  32'(nwr), 3);
    chk("to_rerun_done", 32'(saw_done), 1);

    // Abort after 2 writes
    nwr = 0; saw_done = 0;
    step(1, 1, 0, 8, 1, 1);
    for (int i = 0; i < 30 && nwr < 2; i++) begin
      step(1, 0, 0, 8, 1, 1);
      if (o_wr) nwr++;
    end
    chk("ab_two_writes", 32'(nwr), 2);
    step(1, 0, 1, 8, 0, 1);
    step(1, 0, 0, 8, 1, 1);
    chk("ab_state", 32'(o_state), 0);
    chk("ab_wr",    32'(o_wr), 0);
    chk("ab_busy",  32'(o_busy), 0);
    repeat (15) begin
      step(1, 0, 0, 8, 1, 1);
      if (o_done) saw_done = 1;
    end
    chk("ab_no_done", 32'(saw_done), 0);

    // Start with zero length is ignored
    step(1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    chk("len0_idle", 32'(o_state), 0);

    // Single-sample burst
    nwr = 0; saw_done = 0;
    step(1, 1, 0, 1, 1, 1);
    repeat (15) begin
      step(1, 0, 0, 1, 1, 1);
      if (o_wr) nwr++;
      if (o_done) saw_done = 1;
    end
    chk("len1_nwr",  32'(nwr), 1);
    chk("len1_done", 32'(saw_done), 1);

    // Start while busy is ignored, and the latched length stays
    nwr = 0;
    step(1, 1, 0, 3, 1, 1);
    repeat (25) begin
      step(1, 1, 0, 9, 1, 1);
      if (o_wr) nwr++;
      if (o_done) break;
    end
    chk("busy_start_nwr", 32'(nwr), 3);
    step(1, 0, 0, 3, 0, 0);

    // Reset mid-burst
    step(1, 1, 0, 5, 1, 1);
    repeat (10) step(1, 0, 0, 5, 1, 1);
    step(0, 0, 0, 5, 1, 1);
    step(1, 0, 0, 5, 1, 1);
    chk("mid_rst_state", 32'(o_state), 0);
    chk("mid_rst_cnt",   32'(o_cnt), 0);
    chk("mid_rst_outs",  32'({o_wr, o_cap, o_busy, o_done, o_terr, o_ovr}), 0);

    // Random traffic
    low_left = 0;
    repeat (3000) begin
      bit rs, st, ab, v, r;
      int len;
      rs  = ($urandom_range(0, 299) != 0);
      ab  = ($urandom_range(0, 79) == 0);
      st  = ($urandom_range(0, 5) == 0);
      len = int'($urandom_range(0, 10));
      v   = ($urandom_range(0, 3) != 0);
      if (low_left > 0) begin
        r = 0; low_left--;
      end else if ($urandom_range(0, 14) == 0) begin
        r = 0; low_left = int'($urandom_range(1, 20));
      end else begin
        r = 1;
      end
      step(rs, st, ab, len, v, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
